// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory store path: access sizes and
// store-unit state encoding.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // A store is rejected when the size is reserved or the address is not
    // naturally aligned for the access width.
    function automatic logic store_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_HALF: bad = lo[0];
            SIZE_WORD: bad = (lo != 2'b00);
            SIZE_RSVD: bad = 1'b1;
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: places the low byte/halfword of a register value
// into the addressed lane(s) of an existing memory word.
module store_lane_merge
    import mips_mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    output logic [31:0] merged
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // Bit position of byte lane gi inside the word for the chosen endianness.
            localparam int         LO      = BIG_ENDIAN ? (24 - 8 * gi) : (8 * gi);
            localparam logic [1:0] LANE    = 2'(gi);
            localparam bit         HI_HALF = ((gi % 2) == 1) != BIG_ENDIAN;

            logic       hit;
            logic [7:0] src;

            always_comb begin
                hit = 1'b0;
                src = data[7:0];
                case (size)
                    SIZE_BYTE: hit = (addr == LANE);
                    SIZE_HALF: begin
                        hit = (addr[1] == LANE[1]);
                        src = HI_HALF ? data[15:8] : data[7:0];
                    end
                    SIZE_WORD: begin
                        hit = 1'b1;
                        src = data[LO +: 8];
                    end
                    default: hit = 1'b0;
                endcase
            end

            assign merged[LO +: 8] = hit ? src : old_word[LO +: 8];
        end
    endgenerate

endmodule

// File: rtl/store_narrow_rmw.sv
// Store narrowing unit: word stores go straight to memory, byte/half stores
// perform a read-modify-write against a word-only data memory.
module store_narrow_rmw
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rack,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_wack
);

    state_t             state_reg, state_next;
    logic [1:0]         size_reg, size_next;
    logic [1:0]         lane_reg, lane_next;
    logic [31:0]        wdata_reg, wdata_next;
    logic               req_ready_reg, req_ready_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;
    logic               mem_rd_reg, mem_rd_next;
    logic               mem_wr_reg, mem_wr_next;
    logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
    logic [31:0]        mem_wdata_reg, mem_wdata_next;
    logic [31:0]        merged_word;
    logic               accept;

    store_lane_merge #(.BIG_ENDIAN(BIG_ENDIAN)) u_merge (
        .old_word (mem_rdata),
        .data     (wdata_reg),
        .addr     (lane_reg),
        .size     (size_reg),
        .merged   (merged_word)
    );

    // req_ready is only ever high in IDLE, so it doubles as the accept qualifier.
    assign accept = req_valid && req_ready_reg;

    always_comb begin
        state_next     = state_reg;
        size_next      = size_reg;
        lane_next      = lane_reg;
        wdata_next     = wdata_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    size_next  = req_size;
                    lane_next  = req_addr[1:0];
                    wdata_next = req_wdata;
                    if (store_misaligned(req_size, req_addr[1:0])) begin
                        err_next = 1'b1;
                    end else begin
                        mem_addr_next = {req_addr[ADDR_W-1:2], 2'b00};
                        if (req_size == SIZE_WORD) begin
                            mem_wdata_next = req_wdata;
                            state_next     = ST_WRITE;
                        end else begin
                            state_next = ST_READ;
                        end
                    end
                end
            end
            ST_READ: begin
                if (mem_rack) begin
                    mem_wdata_next = merged_word;
                    state_next     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_wack) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Strobes follow the state being entered so they appear in its first cycle.
        mem_rd_next    = (state_next == ST_READ);
        mem_wr_next    = (state_next == ST_WRITE);
        // Ready is held low through the done cycle so requests never overlap it.
        req_ready_next = (state_next == ST_IDLE) && (state_reg != ST_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            size_reg      <= SIZE_BYTE;
            lane_reg      <= 2'b00;
            wdata_reg     <= '0;
            req_ready_reg <= 1'b1;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            size_reg      <= size_next;
            lane_reg      <= lane_next;
            wdata_reg     <= wdata_next;
            req_ready_reg <= req_ready_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            mem_rd_reg    <= mem_rd_next;
            mem_wr_reg    <= mem_wr_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
        end
    end

    assign req_ready = req_ready_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_rd    = mem_rd_reg;
    assign mem_wr    = mem_wr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: byte-view reference memory, queue scoreboard,
// randomized memory-ack delays with spurious acks.
module tb_store_narrow_rmw;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, done, err, mem_rd, mem_wr, mem_rack, mem_wack;
    logic [31:0] req_addr, req_wdata, mem_addr, mem_rdata, mem_wdata;
    logic [1:0]  req_size;

    store_narrow_rmw #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .done(done), .err(err), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_rack(mem_rack), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_wack(mem_wack)
    );

    // Stand-alone big-endian merge, checked combinationally.
    logic [31:0] mg_old, mg_data, mg_out;
    logic [1:0]  mg_addr, mg_size;
    store_lane_merge #(.BIG_ENDIAN(1'b1)) u_merge_be (
        .old_word(mg_old), .data(mg_data), .addr(mg_addr), .size(mg_size), .merged(mg_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model in terms of memory bytes: byte k is the byte at address word+k.
    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] data,
                                                input logic [1:0] a, input logic [1:0] sz, input bit be);
        logic [7:0]  b [4];
        logic [31:0] res;
        for (int k = 0; k < 4; k++) b[k] = be ? old[31-8*k -: 8] : old[8*k +: 8];
        if (sz == SZ_W) return data;
        if (sz == SZ_B) b[a] = data[7:0];
        if (sz == SZ_H) begin
            b[{a[1], 1'b0}] = be ? data[15:8] : data[7:0];
            b[{a[1], 1'b1}] = be ? data[7:0]  : data[15:8];
        end
        res = '0;
        for (int k = 0; k < 4; k++) begin
            if (be) res[31-8*k -: 8] = b[k];
            else    res[8*k +: 8]    = b[k];
        end
        return res;
    endfunction

    function automatic bit model_bad(input logic [1:0] a, input logic [1:0] sz);
        return (sz == SZ_R) || (sz == SZ_H && a[0]) || (sz == SZ_W && a != 2'b00);
    endfunction

    function automatic logic [31:0] init_word(input int k);
        return (32'h0101_0101 * k) ^ 32'hC3A5_5A3C;
    endfunction

    // ---------------- memory responder (16 words, aliased on addr[5:2]) ----------------
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    bit          mem_inited = 1'b0;
    int          rd_cnt = 0, wr_cnt = 0, rd_dly_r = 0, wr_dly_r = 0;
    int          rd_dly_cfg, wr_dly_cfg, max_dly;
    bit          rand_dly, noise;
    logic        noise_bit = 1'b0;
    bit          pl_en;
    int          pl_idx;
    logic [31:0] pl_val;
    int          rd_dly, wr_dly;

    assign rd_dly    = rand_dly ? rd_dly_r : rd_dly_cfg;
    assign wr_dly    = rand_dly ? wr_dly_r : wr_dly_cfg;
    assign mem_rack  = (mem_rd && rd_cnt >= rd_dly) || (!mem_rd && noise_bit);
    assign mem_wack  = (mem_wr && wr_cnt >= wr_dly) || (!mem_wr && noise_bit);
    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int k = 0; k < 16; k++) mem[k] <= init_word(k);
            mem_inited <= 1'b1;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end
        if (!rst_n) begin
            rd_cnt <= 0;
            wr_cnt <= 0;
        end else begin
            if (mem_rd && mem_rack) begin
                rd_cnt   <= 0;
                rd_dly_r <= $urandom_range(0, max_dly);
            end else if (mem_rd) rd_cnt <= rd_cnt + 1;
            if (mem_wr && mem_wack) begin
                mem[mem_addr[5:2]] <= mem_wdata;
                wr_cnt   <= 0;
                wr_dly_r <= $urandom_range(0, max_dly);
            end else if (mem_wr) wr_cnt <= wr_cnt + 1;
        end
        noise_bit <= noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_err;
        bit          sub;
        logic [31:0] addr;
        logic [31:0] word;
        int          acc;
    } exp_t;
    exp_t q[$];

    int          rd_cycles = 0, wr_cycles = 0;
    bit          prev_rack = 1'b0, prev_wack = 1'b0;
    logic [31:0] wr_cap, wr_addr_cap;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            rd_cycles = 0; wr_cycles = 0; prev_rack = 0; prev_wack = 0;
        end else begin
            if (mem_rd && mem_wr) check("strobe_overlap", 1'b1, 1'b0);
            if (mem_rd && prev_rack) check("rd_held_after_ack", mem_rd, 1'b0);
            if (mem_wr && prev_wack) check("wr_held_after_ack", mem_wr, 1'b0);
            if (mem_wr) begin
                if (wr_cycles == 0) begin
                    wr_cap = mem_wdata; wr_addr_cap = mem_addr;
                end else begin
                    check("wdata_stable", mem_wdata, wr_cap);
                end
                wr_cycles++;
            end
            if (mem_rd) rd_cycles++;
            prev_rack = mem_rd && mem_rack;
            prev_wack = mem_wr && mem_wack;
            if (err || done) begin
                if (q.size() == 0) begin
                    check("resp_without_request", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    if (err) begin
                        check("err_expected", e.is_err, 1'b1);
                        check("err_with_done", done, 1'b0);
                        check("err_latency", cyc - e.acc, 1);
                        check("err_no_mem_access", rd_cycles + wr_cycles, 0);
                        check("err_ready_stays", req_ready, 1'b1);
                    end else begin
                        check("done_expected", e.is_err, 1'b0);
                        check("wrote", wr_cycles > 0, 1'b1);
                        check("mem_wdata", wr_cap, e.word);
                        check("mem_addr", wr_addr_cap, e.addr);
                        check("read_used", rd_cycles != 0, e.sub);
                        check("done_latency", cyc - e.acc, 2 + rd_cycles + wr_cycles);
                        $display("[TB] store addr=0x%08h wdata=0x%08h rd=%0d wr=%0d lat=%0d",
                                 e.addr, wr_cap, rd_cycles, wr_cycles, cyc - e.acc);
                    end
                end
                rd_cycles = 0;
                wr_cycles = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic preload(input int idx, input logic [31:0] v);
        pl_idx = idx; pl_val = v; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_mem[idx] = v;
    endtask

    task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        exp_t e;
        bit   got;
        req_valid = 1'b1; req_addr = a; req_size = sz; req_wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (req_ready) begin got = 1'b1; break; end
        end
        check("accept_in_time", got, 1'b1);
        if (!got) begin req_valid = 1'b0; return; end
        check("no_overlap", q.size(), 0);
        e.is_err = model_bad(a[1:0], sz);
        e.sub    = (sz != SZ_W);
        e.addr   = {a[31:2], 2'b00};
        e.acc    = cyc;
        e.word   = '0;
        if (!e.is_err) begin
            e.word = model_merge(ref_mem[a[5:2]], wd, a[1:0], sz, 1'b0);
            ref_mem[a[5:2]] = e.word;
        end
        q.push_back(e);
        $display("[TB] accept addr=0x%08h size=%0d wdata=0x%08h err=%0d", a, sz, wd, e.is_err);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_size = 2'($urandom); req_wdata = $urandom;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (q.size() == 0 && req_ready) begin ok = 1'b1; break; end
        end
        check("drain_in_time", ok, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved, a, wd;
        logic [1:0]  sz;
        bit          seen, ok;
        int          r;

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
        rand_dly = 1'b0; rd_dly_cfg = 0; wr_dly_cfg = 0; max_dly = 0; noise = 1'b0;
        pl_en = 1'b0; pl_idx = 0; pl_val = '0;
        mg_old = '0; mg_data = '0; mg_addr = '0; mg_size = '0;
        for (int k = 0; k < 16; k++) ref_mem[k] = init_word(k);

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // sb into lane 1, little endian
        preload(0, 32'h1122_3344);
        issue(32'h0000_1001, SZ_B, 32'hFFFF_FFAB);
        wait_idle();
        check("sb_vector", mem[0], 32'h1122_AB44);

        // sh into upper half, little endian; same vector through the big-endian merge
        preload(0, 32'hAAAA_AAAA);
        issue(32'h0000_2002, SZ_H, 32'h0000_BEEF);
        wait_idle();
        check("sh_le_vector", mem[0], 32'hBEEF_AAAA);
        mg_old = 32'hAAAA_AAAA; mg_data = 32'h0000_BEEF; mg_addr = 2'b10; mg_size = SZ_H;
        #1;
        check("sh_be_vector", mg_out, 32'hAAAA_BEEF);

        // zero-wait word store
        issue(32'h0000_3000, SZ_W, 32'hDEAD_BEEF);
        wait_idle();
        check("sw_vector", mem[0], 32'hDEAD_BEEF);

        // misaligned half and reserved size, back to back
        issue(32'h0000_4001, SZ_H, 32'h1234_5678);
        issue(32'h0000_4000, SZ_R, 32'h1234_5678);
        wait_idle();

        // back-to-back byte stores with slow reads, req_valid held between them
        rd_dly_cfg = 2; wr_dly_cfg = 1;
        issue(32'h0000_1002, SZ_B, 32'h0000_0077);
        issue(32'h0000_1003, SZ_B, 32'h1234_5699);
        wait_idle();
        check("b2b_word", mem[0], 32'h9977_BEEF);

        // reset abort during WRITE
        rd_dly_cfg = 3; wr_dly_cfg = 1000;
        saved = ref_mem[1];
        issue(32'h0000_1005, SZ_B, 32'h0000_00C3);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_wr) begin ok = 1'b1; break; end
        end
        check("abort_reached_write", ok, 1'b1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_mem_wr_drop", mem_wr, 1'b0);
        check("abort_mem_rd_drop", mem_rd, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_ready", req_ready, 1'b1);
        q.delete();
        ref_mem[1] = saved;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr_dly_cfg = 0; rd_dly_cfg = 0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("abort_no_done", seen, 1'b0);
        check("abort_ready_after", req_ready, 1'b1);
        check("abort_mem_untouched", mem[1], saved);
        @(posedge clk); #1;

        // randomized traffic with random ack delays and spurious acks
        rand_dly = 1'b1; max_dly = 3; noise = 1'b1;
        for (int n = 0; n < 80; n++) begin
            a  = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
            r  = $urandom_range(0, 9);
            sz = (r < 4) ? SZ_B : (r < 7) ? SZ_H : (r < 9) ? SZ_W : SZ_R;
            if (sz != SZ_B && $urandom_range(0, 3) != 0) a[1:0] = (sz == SZ_H) ? {a[1], 1'b0} : 2'b00;
            wd = $urandom;
            issue(a, sz, wd);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_idle();
        noise = 1'b0;
        for (int k = 0; k < 16; k++) check("final_mem", mem[k], ref_mem[k]);

        // big-endian merge against the byte model
        for (int n = 0; n < 24; n++) begin
            mg_old = $urandom; mg_data = $urandom;
            r = $urandom_range(0, 2);
            mg_size = (r == 0) ? SZ_B : (r == 1) ? SZ_H : SZ_W;
            mg_addr = 2'($urandom);
            if (mg_size == SZ_H) mg_addr[0] = 1'b0;
            if (mg_size == SZ_W) mg_addr = 2'b00;
            #1;
            check("be_merge", mg_out, model_merge(mg_old, mg_data, mg_addr, mg_size, 1'b1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
